harvard_data_responder: RTL and testbench

Responder end of the Harvard CPU data bus: decodes `data_address`, serves combinational reads and single-cycle writes to an on-chip word RAM plus a small MMIO window. The MMIO window holds a byte TX FIFO drained over a valid/ready stream, a status register and a free-running cycle counter. It sits opposite `mips_cpu_harvard` in the testbench/top level, replacing a bare data memory.

---
 rtl/harvard_data_responder.sv | 173 +++++++++++++++++
 tb/tb_harvard_data_responder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/harvard_data_responder.sv
// harvard_data_responder: data-side responder for the Harvard CPU bus.
// Serves combinational reads and clocked writes to an on-chip word RAM and a
// small MMIO window (TX byte FIFO, STATUS, optional CYCLES counter).
// Optional feature macro: DATA_RESP_CYCLE_COUNTER_EN (CYCLES register at +0x8).
//
// TX stream handshake: tx_valid is high whenever the FIFO holds a byte and
// tx_data is the head byte; a byte is consumed at any posedge where
// tx_valid && tx_ready, independent of clk_enable. tx_data stays stable
// while tx_valid is high and tx_ready is low.
module harvard_data_responder #(
  parameter logic [31:0] RAM_BASE   = 32'h0000_1000,
  parameter int          RAM_DEPTH  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_error
);

  localparam int          RAM_AW    = $clog2(RAM_DEPTH);
  localparam int          PTR_W     = $clog2(FIFO_DEPTH);
  localparam int          CNT_W     = PTR_W + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_DEPTH) << 2;

  // Storage
  logic [31:0]      mem    [RAM_DEPTH];
  logic [7:0]       buffer [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;

  // Decode
  logic              aligned;
  logic [31:0]       ram_offset;
  logic [RAM_AW-1:0] ram_index;
  logic              ram_hit;
  logic              txdata_hit;
  logic              status_hit;
  logic              cycles_hit;
  logic              mapped;
  logic              access_err;

  // FIFO control
  logic       bus_write;
  logic       empty;
  logic       full;
  logic       push;
  logic       pop;
  logic       push_accept;
  logic [7:0] count_byte;

  assign aligned    = (data_address[1:0] == 2'b00);
  // Offset is only meaningful when the address is at or above RAM_BASE.
  assign ram_offset = data_address - RAM_BASE;
  assign ram_index  = ram_offset[RAM_AW+1:2];
  assign ram_hit    = aligned && (data_address >= RAM_BASE) && (ram_offset < RAM_BYTES);
  assign txdata_hit = aligned && (data_address == MMIO_BASE);
  assign status_hit = aligned && (data_address == MMIO_BASE + 32'd4);

`ifdef DATA_RESP_CYCLE_COUNTER_EN
  logic [31:0] cycles;
  assign cycles_hit = aligned && (data_address == MMIO_BASE + 32'd8);
`else
  assign cycles_hit = 1'b0;
`endif

  assign mapped     = ram_hit || txdata_hit || status_hit || cycles_hit;
  assign access_err = (data_read || data_write) && !mapped;

  assign bus_write   = data_write && clk_enable;
  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign push        = bus_write && txdata_hit;
  assign pop         = tx_valid && tx_ready;
  // A push into a full FIFO survives only if the head leaves in the same edge.
  assign push_accept = push && (!full || pop);
  assign count_byte  = 8'(count);

  assign tx_valid = !empty;
  assign tx_data  = buffer[rd_ptr];

  // Combinational read mux; reads see pre-write state in the write cycle.
  always_comb begin
    data_readdata = '0;
    if (data_read) begin
      if (ram_hit) begin
        data_readdata = mem[ram_index];
      end else if (status_hit) begin
        data_readdata = {16'h0000, count_byte, 5'b00000, overflow, full, empty};
      end
`ifdef DATA_RESP_CYCLE_COUNTER_EN
      else if (cycles_hit) begin
        data_readdata = cycles;
      end
`endif
    end
  end

  // RAM word write; contents are deliberately not touched by reset.
  always_ff @(posedge clk) begin
    if (bus_write && ram_hit) begin
      mem[ram_index] <= data_writedata;
    end
  end

  // FIFO byte storage; stale entries are harmless once the pointers reset.
  always_ff @(posedge clk) begin
    if (push_accept) begin
      buffer[wr_ptr] <= data_writedata[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      case ({push_accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end else if (bus_write && status_hit && data_writedata[2]) begin
        overflow <= 1'b0;
      end
    end
  end

  // Sticky bus error on any unmapped or misaligned access.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_error <= 1'b0;
    end else if (access_err) begin
      bus_error <= 1'b1;
    end
  end

`ifdef DATA_RESP_CYCLE_COUNTER_EN
  // Free-running cycle counter; a bus clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycles <= '0;
    end else if (bus_write && cycles_hit) begin
      cycles <= '0;
    end else if (clk_enable) begin
      cycles <= cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_harvard_data_responder.sv
// Testbench for harvard_data_responder: directed scenarios with literal
// expectations, then randomized bus/stream traffic checked every cycle
// against a queue/array reference model.
module tb_harvard_data_responder;

  localparam logic [31:0] RAM_BASE   = 32'h0000_1000;
  localparam int          RAM_DEPTH  = 1024;
  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;
  localparam int          FIFO_DEPTH = 8;
  localparam logic [31:0] TX_ADDR    = MMIO_BASE;
  localparam logic [31:0] ST_ADDR    = MMIO_BASE + 32'd4;
  localparam logic [31:0] CY_ADDR    = MMIO_BASE + 32'd8;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_error;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  harvard_data_responder #(
    .RAM_BASE  (RAM_BASE),
    .RAM_DEPTH (RAM_DEPTH),
    .MMIO_BASE (MMIO_BASE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable    (clk_enable),
    .data_address  (data_address),
    .data_write    (data_write),
    .data_read     (data_read),
    .data_writedata(data_writedata),
    .data_readdata (data_readdata),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .bus_error     (bus_error)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [7:0]  exp_q[$];          // expected TX FIFO contents, head first
  logic [31:0] ram_m[int];        // expected RAM words by index
  logic        m_ovf      = 1'b0;
  logic        m_berr     = 1'b0;
  logic [31:0] m_cycles   = '0;
  bit          model_live = 1'b0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_ram_hit(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (longint'(a) >= longint'(RAM_BASE)) &&
           (longint'(a) < longint'(RAM_BASE) + 4 * RAM_DEPTH);
  endfunction

  function automatic bit m_cyc_hit(input logic [31:0] a);
`ifdef DATA_RESP_CYCLE_COUNTER_EN
    return a == CY_ADDR;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_mapped(input logic [31:0] a);
    return m_ram_hit(a) || a == TX_ADDR || a == ST_ADDR || m_cyc_hit(a);
  endfunction

  function automatic logic [31:0] exp_read(input logic rd, input logic [31:0] a);
    int          idx;
    int          n;
    logic [31:0] st;
    if (!rd) return '0;
    if (m_ram_hit(a)) begin
      idx = int'((a - RAM_BASE) >> 2);
      return ram_m.exists(idx) ? ram_m[idx] : 32'h0;
    end
    if (a == ST_ADDR) begin
      n  = exp_q.size();
      st = '0;
      st[15:8] = 8'(n);
      st[2]    = m_ovf;
      st[1]    = (n == FIFO_DEPTH);
      st[0]    = (n == 0);
      return st;
    end
    if (m_cyc_hit(a)) return m_cycles;
    return '0;
  endfunction

  // Model state advances on every posedge from the stable bus inputs.
  initial begin : model_proc
    logic [31:0] a;
    bit          wr_en;
    bit          do_pop;
    bit          was_full;
    forever begin
      @(posedge clk);
      a     = data_address;
      wr_en = data_write && clk_enable;
      if (reset) begin
        exp_q.delete();
        m_ovf      = 1'b0;
        m_berr     = 1'b0;
        m_cycles   = '0;
        model_live = 1'b1;
      end else begin
        if ((data_read || data_write) && !m_mapped(a)) m_berr = 1'b1;
        was_full = (exp_q.size() == FIFO_DEPTH);
        do_pop   = (exp_q.size() != 0) && tx_ready;
        if (do_pop) void'(exp_q.pop_front());
        if (wr_en && a == TX_ADDR) begin
          if (!was_full || do_pop) exp_q.push_back(data_writedata[7:0]);
          else m_ovf = 1'b1;
        end
        if (wr_en && a == ST_ADDR && data_writedata[2]) m_ovf = 1'b0;
        if (wr_en && m_ram_hit(a)) ram_m[int'((a - RAM_BASE) >> 2)] = data_writedata;
        if (wr_en && m_cyc_hit(a)) m_cycles = '0;
        else if (clk_enable) m_cycles = m_cycles + 32'd1;
      end
    end
  end

  // One compare process: outputs vs model on every cycle after reset.
  initial begin : compare_proc
    forever begin
      @(negedge clk);
      if (model_live) begin
        check32("readdata", data_readdata, exp_read(data_read, data_address));
        check32("tx_valid", {31'b0, tx_valid}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) check32("tx_data", {24'b0, tx_data}, {24'b0, exp_q[0]});
        check32("bus_error", {31'b0, bus_error}, {31'b0, m_berr});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    data_address   = a;
    data_writedata = d;
    data_write     = 1'b1;
    tick();
    data_write = 1'b0;
  endtask

  task automatic bus_rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    data_address = a;
    data_read    = 1'b1;
    @(negedge clk);
    check32(name, data_readdata, exp);
    tick();
    data_read = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    int k;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: begin
        k = $urandom_range(0, 16);
        if (k == 16) k = RAM_DEPTH - 1;
        return RAM_BASE + 32'(4 * k);
      end
      4, 5:    return TX_ADDR;
      6:       return ST_ADDR;
      7:       return CY_ADDR;
      default: begin
        case ($urandom_range(0, 4))
          0:       return 32'h0000_0FFC;
          1:       return RAM_BASE + 32'(4 * RAM_DEPTH);
          2:       return MMIO_BASE + 32'hC;
          3:       return 32'h0000_1002;
          default: return MMIO_BASE + 32'd1;
        endcase
      end
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset          = 1'b1;
    clk_enable     = 1'b1;
    data_address   = '0;
    data_write     = 1'b0;
    data_read      = 1'b0;
    data_writedata = '0;
    tx_ready       = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check32("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check32("rst_bus_error", {31'b0, bus_error}, 32'h0);
    check32("rst_readdata_idle", data_readdata, 32'h0);
    tick();
    bus_rd_check("rst_status", ST_ADDR, 32'h0000_0001);

    // Known RAM contents for the words the bench touches
    for (int i = 0; i < 16; i++) bus_wr(RAM_BASE + 32'(4 * i), 32'hA500_0000 | 32'(i));
    bus_wr(RAM_BASE + 32'(4 * (RAM_DEPTH - 1)), 32'hA500_0000 | 32'(RAM_DEPTH - 1));
    bus_rd_check("ram_last_word", RAM_BASE + 32'(4 * (RAM_DEPTH - 1)), 32'hA500_03FF);

    // RAM round trip, then a write with clk_enable low must not land
    bus_wr(32'h0000_1004, 32'hDEAD_BEEF);
    bus_rd_check("ram_roundtrip", 32'h0000_1004, 32'hDEAD_BEEF);
    clk_enable = 1'b0;
    bus_wr(32'h0000_1004, 32'h1234_5678);
    clk_enable = 1'b1;
    bus_rd_check("ram_write_disabled", 32'h0000_1004, 32'hDEAD_BEEF);

    // FIFO stream
    bus_wr(TX_ADDR, 32'h41);
    bus_wr(TX_ADDR, 32'h42);
    bus_wr(TX_ADDR, 32'h43);
    bus_rd_check("fifo_status3", ST_ADDR, 32'h0000_0300);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("fifo_drain_byte", {24'b0, tx_data}, 32'h41 + 32'(i));
      tick();
    end
    @(negedge clk);
    check32("fifo_drained_valid", {31'b0, tx_valid}, 32'h0);
    tick();
    bus_rd_check("fifo_status_empty", ST_ADDR, 32'h0000_0001);

    // Overflow
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) bus_wr(TX_ADDR, 32'h50 + 32'(i));
    bus_rd_check("ovf_status", ST_ADDR, 32'h0000_0806);
    bus_wr(ST_ADDR, 32'h4);
    bus_rd_check("ovf_cleared", ST_ADDR, 32'h0000_0802);
    tx_ready = 1'b1;
    bus_wr(TX_ADDR, 32'hAA);
    tx_ready = 1'b0;
    bus_rd_check("full_push_pop", ST_ADDR, 32'h0000_0802);
    @(negedge clk);
    check32("full_push_pop_head", {24'b0, tx_data}, 32'h51);
    tick();
    tx_ready = 1'b1;
    repeat (8) tick();
    tx_ready = 1'b0;

    // Reset mid-stream, with a TXDATA write during reset
    bus_wr(TX_ADDR, 32'h61);
    bus_wr(TX_ADDR, 32'h62);
    bus_wr(TX_ADDR, 32'h63);
    reset = 1'b1;
    bus_wr(TX_ADDR, 32'h99);
    reset = 1'b0;
    @(negedge clk);
    check32("midrst_tx_valid", {31'b0, tx_valid}, 32'h0);
    tick();
    bus_rd_check("midrst_status", ST_ADDR, 32'h0000_0001);
    bus_rd_check("midrst_ram_kept", 32'h0000_1004, 32'hDEAD_BEEF);

    // Errors
    bus_rd_check("unmapped_read", 32'h0000_0FFC, 32'h0);
    @(negedge clk);
    check32("unmapped_bus_error", {31'b0, bus_error}, 32'h1);
    tick();
    bus_wr(32'h0000_1002, 32'hFFFF_FFFF);
    bus_rd_check("misaligned_write_ignored", 32'h0000_1000, 32'hA500_0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check32("bus_error_reset", {31'b0, bus_error}, 32'h0);
    tick();

`ifdef DATA_RESP_CYCLE_COUNTER_EN
    bus_wr(CY_ADDR, 32'h0);
    repeat (10) tick();
    bus_rd_check("cycles_ten", CY_ADDR, 32'd10);
    bus_wr(CY_ADDR, 32'h0);
    bus_rd_check("cycles_clear_wins", CY_ADDR, 32'd0);
`else
    bus_rd_check("cycles_unmapped", CY_ADDR, 32'h0);
    @(negedge clk);
    check32("cycles_unmapped_err", {31'b0, bus_error}, 32'h1);
    tick();
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 199) == 0);
      clk_enable     = ($urandom_range(0, 7) != 0);
      tx_ready       = ($urandom_range(0, 2) == 0);
      data_address   = pick_addr();
      data_read      = 1'($urandom_range(0, 1));
      data_write     = !reset && ($urandom_range(0, 1) == 1);
      data_writedata = $urandom;
      tick();
    end
    reset      = 1'b0;
    data_write = 1'b0;
    data_read  = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
